// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction fetch (IF) and load/store (D).
// Ports: clk/rst (async, active-high)/clk_en; IF side if_req/if_addr -> if_rdata/if_valid;
// D side d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid; memory side mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata;
// busy is high whenever an access is in flight.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LATENCY = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] LAT = LATENCY[3:0];
  localparam logic [3:0] MAXS = MAX_STREAK[3:0];
  state_t state, state_n;
  logic owner_d;
  logic we_q;
  logic [3:0] streak;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic grant_d;
  logic grant;
  // D wins unless IF is also waiting and D has already used up its streak allowance
  assign grant_d = d_req && (!if_req || streak < MAXS);
  assign grant = state == IDLE && (if_req || d_req);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (clk_en) state <= state_n;
  end
  always_comb begin
    state_n = state;
    mem_en = 1'b0;
    mem_we = 1'b0;
    if_valid = 1'b0;
    d_valid = 1'b0;
    busy = state != IDLE;
    mem_addr = addr_q;
    mem_wdata = wdata_q;
    case (state)
      IDLE: state_n = (if_req || d_req) ? ISSUE : IDLE;
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_q;
        state_n = we_q ? DONE : WAIT;
      end
      WAIT: state_n = cnt == 4'd1 ? DONE : WAIT;
      default: begin
        if_valid = !owner_d;
        d_valid = owner_d;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d <= 1'b0;
      we_q <= 1'b0;
      streak <= '0;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else if (clk_en) begin
      if (grant) begin
        owner_d <= grant_d;
        we_q <= grant_d && d_we;
        addr_q <= grant_d ? d_addr : if_addr;
        wdata_q <= d_wdata;
        streak <= (grant_d && if_req) ? (streak == MAXS ? streak : streak + 4'd1) : 4'd0;
      end
      if (state == ISSUE) cnt <= LAT;
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && owner_d) d_rdata <= mem_rdata;
        if (cnt == 4'd1 && !owner_d) if_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with LATENCY=1 and LATENCY=3 instances.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, if_req3 = 1'b0, d_req3 = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_valid, d_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic if_valid3, d_valid3, mem_en3, mem_we3, busy3;
  int n_tot = 0;
  int n_bad = 0;
  logic [31:0] q_if[$];
  logic [31:0] q_d[$];
  logic [31:0] last_d = '0;
  logic [31:0] p1 = '0;
  logic [31:0] p3 [3] = '{32'h0, 32'h0, 32'h0};
  logic [7:0] seq;
  int g;
  logic done;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .MAX_STREAK(4)) u1 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .MAX_STREAK(4)) u3 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .if_req(if_req3), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata3), .d_valid(d_valid3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .busy(busy3));

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h40 ? 32'h2002000A : {a[15:0], ~a[15:0]} ^ 32'h13572468;
  endfunction

  // memory models: data appears LATENCY enabled cycles after mem_en, zero otherwise
  always @(posedge clk) if (clk_en) p1 <= mem_en ? rom(mem_addr) : 32'h0;
  always @(posedge clk) if (clk_en) begin
    p3[0] <= mem_en3 ? rom(mem_addr3) : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata = p1;
  assign mem_rdata3 = p3[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every completion pulse of u1 consumes one expectation of its requester
  always @(negedge clk) if (!rst && clk_en && (if_valid || d_valid)) begin
    chk("excl_valid", {63'b0, if_valid & d_valid}, 64'd0);
    if (if_valid) begin
      chk("if_q_nonempty", {63'b0, q_if.size() != 0}, 64'd1);
      if (q_if.size() != 0) chk("if_rdata", {32'b0, if_rdata}, {32'b0, q_if.pop_front()});
    end
    if (d_valid) begin
      chk("d_q_nonempty", {63'b0, q_d.size() != 0}, 64'd1);
      if (q_d.size() != 0) chk("d_rdata", {32'b0, d_rdata}, {32'b0, q_d.pop_front()});
    end
  end

  task automatic wait_v(input bit d, output int k);
    bit seen = 0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (clk_en && (d ? d_valid : if_valid)) begin
        seen = 1;
        break;
      end
    end
    chk(d ? "d_timeout" : "if_timeout", {63'b0, seen}, 64'd1);
  endtask

  task automatic if_access(input logic [31:0] a, output int k);
    if_addr = a;
    if_req = 1'b1;
    q_if.push_back(rom(a));
    wait_v(0, k);
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd, output int k);
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    if (!we) last_d = rom(a);
    q_d.push_back(last_d);
    wait_v(1, k);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic watch(input int n, output int cnt, output logic [31:0] a, output logic [31:0] wd, output logic we);
    cnt = 0;
    a = '0;
    wd = '0;
    we = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (clk_en && mem_en) begin
        cnt++;
        a = mem_addr;
        wd = mem_wdata;
        we = mem_we;
      end
    end
  endtask

  task automatic contention();
    int ki, kd;
    seq = '0;
    g = 0;
    fork
      if_access(32'h200, ki);
      begin
        d_we = 1'b0;
        d_addr = 32'h300;
        d_req = 1'b1;
        last_d = rom(32'h300);
        q_d.push_back(last_d);
        for (int i = 0; i < 5; i++) begin
          wait_v(1, kd);
          if (i < 4) q_d.push_back(last_d);
        end
        @(posedge clk);
        #1 d_req = 1'b0;
      end
      for (int c = 0; c < 200 && g < 6; c++) begin
        @(negedge clk);
        if (clk_en && mem_en) begin
          seq = {seq[6:0], mem_addr != 32'h200};
          g++;
        end
      end
    join
    @(posedge clk);
    #1;
    chk("grant_cnt", 64'(g), 64'd6);
    chk("grant_seq", {56'b0, seq}, 64'h3D);
  endtask

  initial begin
    int k, cnt, edges, nv;
    logic [31:0] a, wd;
    logic we, seen;
    logic [35:0] snap;
    #1;
    chk("reset_async", {if_rdata, d_rdata}, 64'd0);
    chk("reset_ctl", {54'b0, if_valid, d_valid, mem_en, mem_we, busy, busy3, mem_en3, if_valid3, d_valid3, 1'b0}, 64'd0);
    chk("reset_mem", {mem_addr, mem_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    fork
      if_access(32'h40, k);
      watch(6, cnt, a, wd, we);
    join
    @(posedge clk);
    #1;
    chk("t1_lat", 64'(k), 64'd3);
    chk("t1_en_cnt", 64'(cnt), 64'd1);
    chk("t1_addr", {32'b0, a}, 64'h40);
    chk("t1_rdata", {32'b0, if_rdata}, 64'h2002000A);
    d_access(1'b0, 32'h104, 32'h0, k);
    chk("ld_lat", 64'(k), 64'd3);
    fork
      d_access(1'b1, 32'h100, 32'hDEADBEEF, k);
      watch(6, cnt, a, wd, we);
    join
    @(posedge clk);
    #1;
    chk("st_lat", 64'(k), 64'd2);
    chk("st_en_cnt", 64'(cnt), 64'd1);
    chk("st_mem", {a, wd}, {32'h100, 32'hDEADBEEF});
    chk("st_we", {63'b0, we}, 64'd1);
    chk("st_drdata", {32'b0, d_rdata}, {32'b0, rom(32'h104)});
    contention();
    contention();
    // clk_en toggling during a LATENCY=3 fetch
    if_addr = 32'h80;
    if_req3 = 1'b1;
    clk_en = 1'b1;
    edges = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_valid3) begin
        seen = 1'b1;
        break;
      end
      snap = {busy3, mem_en3, if_valid3, d_valid3, if_rdata3};
      if (clk_en) edges++;
      @(posedge clk);
      #1;
      if (!clk_en) chk("t4_frozen", {28'b0, busy3, mem_en3, if_valid3, d_valid3, if_rdata3}, {28'b0, snap});
      clk_en = ~clk_en;
    end
    chk("t4_seen", {63'b0, seen}, 64'd1);
    chk("t4_edges", 64'(edges), 64'd5);
    chk("t4_rdata", {32'b0, if_rdata3}, {32'b0, rom(32'h80)});
    @(posedge clk);
    #1;
    chk("t4_valid_hold", {63'b0, if_valid3 & ~clk_en}, 64'd1);
    clk_en = 1'b1;
    @(posedge clk);
    #1 if_req3 = 1'b0;
    chk("t4_valid_drop", {63'b0, if_valid3}, 64'd0);
    // reset in the middle of a LATENCY=3 fetch
    @(posedge clk);
    #1 if_addr = 32'h88;
    if_req3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_inwait", {62'b0, busy3, mem_en3}, 64'd2);
    #1 rst = 1'b1;
    #1 chk("t5_rst_async", {61'b0, busy3, mem_en3, if_valid3}, 64'd0);
    if_req3 = 1'b0;
    last_d = '0;
    @(negedge clk) rst = 1'b0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      nv += int'(if_valid3);
    end
    chk("t5_no_valid", 64'(nv), 64'd0);
    @(posedge clk);
    #1 d_addr = 32'h84;
    d_we = 1'b0;
    d_req3 = 1'b1;
    seen = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_valid3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_d_seen", {63'b0, seen}, 64'd1);
    chk("t5_d_lat", 64'(k), 64'd5);
    chk("t5_d_rdata", {32'b0, d_rdata3}, {32'b0, rom(32'h84)});
    @(posedge clk);
    #1 d_req3 = 1'b0;
    // random traffic from both requesters with random clock enable
    done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 500; i++) begin
            int ki;
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk);
              #1;
            end
            if_access(32'h1000 + (32'($urandom_range(0, 1023)) << 2), ki);
          end
          for (int i = 0; i < 500; i++) begin
            int kd;
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk);
              #1;
            end
            d_access($urandom_range(0, 2) == 0, 32'($urandom_range(0, 1023)) << 2, 32'($urandom), kd);
          end
        join
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 clk_en = done || ($urandom_range(0, 4) != 0);
      end
    join
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    chk("q_if_empty", 64'(q_if.size()), 64'd0);
    chk("q_d_empty", 64'(q_d.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
